// File: rtl/bpu_update_queue.sv
// Update buffer between branch feedback and the predictor table write port; coalesces same-pc updates.
// Latency 1 cycle from enqueue to wr_valid on an empty queue; drops and counts when full with no dequeue.
package bpu_pkg;
    typedef struct packed {
        logic [29:0] pc;
        logic [31:0] br_target;
        logic        br_taken;
        logic [1:0]  br_type;
        logic        btb_update;
        logic        bht_update;
        logic        lpht_update;
        logic [1:0]  lphr;
        logic [9:0]  lphr_index;
        logic        flush;
    } bpu_update_t;
endpackage

module bpu_update_queue
    import bpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enq_valid_i,
    input  logic              csr_flush_i,
    input  bpu_update_t       update_i,
    output logic              wr_valid_o,
    input  logic              wr_ready_i,
    output bpu_update_t       wr_o,
    output logic              full_o,
    output logic [CNT_W-1:0]  drop_cnt_o
);
    localparam int AW = $clog2(DEPTH);

    bpu_update_t     mem [DEPTH];
    bpu_update_t     new_ent;
    logic [AW-1:0]   head, tail, youngest, shown;
    logic [AW:0]     occ;
    logic [CNT_W-1:0] drop_cnt;
    logic            cand, deq, merge, alloc, drop;

    assign youngest   = tail - AW'(1);
    assign wr_valid_o = (occ != '0);
    assign full_o     = (occ == (AW+1)'(DEPTH));
    assign drop_cnt_o = drop_cnt;

    // When empty, the slot just popped still holds the last presented entry.
    assign shown = wr_valid_o ? head : head - AW'(1);
    assign wr_o  = mem[shown];

    assign deq   = wr_valid_o & wr_ready_i;
    assign cand  = enq_valid_i & ~csr_flush_i &
                   (update_i.btb_update | update_i.bht_update | update_i.lpht_update);
    assign merge = cand & wr_valid_o & (mem[youngest].pc == update_i.pc) &
                   ~(deq & (occ == (AW+1)'(1)));
    assign alloc = cand & ~merge & (~full_o | deq);
    assign drop  = cand & ~merge & full_o & ~deq;

    always_comb begin
        new_ent       = update_i;
        new_ent.flush = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (merge) begin
            mem[youngest].br_target   <= update_i.br_target;
            mem[youngest].br_taken    <= update_i.br_taken;
            mem[youngest].br_type     <= update_i.br_type;
            mem[youngest].lphr        <= update_i.lphr;
            mem[youngest].lphr_index  <= update_i.lphr_index;
            mem[youngest].btb_update  <= mem[youngest].btb_update  | update_i.btb_update;
            mem[youngest].bht_update  <= mem[youngest].bht_update  | update_i.bht_update;
            mem[youngest].lpht_update <= mem[youngest].lpht_update | update_i.lpht_update;
        end else if (alloc) begin
            mem[tail] <= new_ent;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head     <= '0;
            tail     <= '0;
            occ      <= '0;
            drop_cnt <= '0;
        end else begin
            if (alloc) tail <= tail + AW'(1);
            if (deq)   head <= head + AW'(1);
            case ({alloc, deq})
                2'b10:   occ <= occ + (AW+1)'(1);
                2'b01:   occ <= occ - (AW+1)'(1);
                default: occ <= occ;
            endcase
            if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end
endmodule
